// File: rtl/mult_arbiter.sv
// mult_arbiter
// Two-port arbiter and sequencer for a shared sequential 8x8 multiplier.
// Each requester offers an operand pair over a valid/ready handshake. The
// granted request is driven to the multiplier with a one-cycle start pulse.
// The block then waits for the multiplier's done flag and returns the
// 16-bit product tagged with the requester ID. A watchdog aborts the
// operation, pulses the multiplier reset and returns an error response if
// done never arrives.
//
// Configuration macro:
//   MULT_ARB_RR_EN  defined   -> round-robin grant between the two ports
//                   undefined -> fixed priority, port 0 always wins
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles without a qualified done before abort (2..255)
//
// Ports:
//   clk, aclr_n                   clock, asynchronous active-low reset
//   req0_* / req1_*               request ports (valid, ready, a, b)
//   rsp_valid/ready/id/product/err  response channel
//   mult_dataa/datab/start/reset_a  drive to the multiplier
//   mult_done, mult_product       status from the multiplier
//   busy                          high whenever the FSM is not in IDLE
module mult_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_product,
  output logic        rsp_err,
  output logic [7:0]  mult_dataa,
  output logic [7:0]  mult_datab,
  output logic        mult_start,
  output logic        mult_reset_a,
  input  logic        mult_done,
  input  logic [15:0] mult_product,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, b_q;
  logic        rsp_id_q;
  logic [15:0] rsp_product_q;
  logic        rsp_err_q;
  logic [7:0]  timer_q;
  logic        done_armed_q;   // done has been seen low at least once in WAIT
  logic        tmo_pulse_q;    // one-cycle multiplier reset after an abort
  logic        grant;          // port selected in IDLE (0 or 1)
  logic        accept;
  logic        done_qual;
  logic        timeout_hit;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef MULT_ARB_RR_EN
  logic last_grant_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant = ~req0_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
  end

  // Reset to 1 so that port 0 wins the first contested arbitration.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      last_grant_q <= 1'b1;
    end else if (state_q == S_RESP && rsp_ready) begin
      last_grant_q <= rsp_id_q;
    end
  end
`else
  // Fixed priority: port 1 is chosen only when port 0 is idle.
  always_comb begin
    grant = ~req0_valid;
  end
`endif

  assign accept      = (state_q == S_IDLE) && (req0_valid || req1_valid);
  // A done left high by the previous operation is ignored until the flag
  // has been observed low inside the current WAIT phase.
  assign done_qual   = done_armed_q && mult_done;
  assign timeout_hit = (timer_q == 8'(TIMEOUT_CYCLES));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aclr_n) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    if (!aclr_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (done_qual || timeout_hit) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == S_IDLE) begin
      req0_ready = req0_valid && !grant;
      req1_ready = req1_valid &&  grant;
    end
    mult_start = (state_q == S_START);
    rsp_valid  = (state_q == S_RESP);
    busy       = (state_q != S_IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath: operands, response, watchdog
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      a_q           <= '0;
      b_q           <= '0;
      rsp_id_q      <= 1'b0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
      timer_q       <= '0;
      done_armed_q  <= 1'b0;
      tmo_pulse_q   <= 1'b0;
    end else begin
      tmo_pulse_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q      <= grant ? req1_a : req0_a;
            b_q      <= grant ? req1_b : req0_b;
            rsp_id_q <= grant;
          end
        end
        S_START: begin
          // The timer counts WAIT cycles inclusively: it reads 1 in the
          // first WAIT cycle and equals TIMEOUT_CYCLES in the last one.
          timer_q      <= 8'd1;
          done_armed_q <= 1'b0;
        end
        S_WAIT: begin
          if (!mult_done)      done_armed_q <= 1'b1;
          if (timer_q != '1)   timer_q      <= timer_q + 8'd1;
          if (done_qual) begin
            rsp_product_q <= mult_product;
            rsp_err_q     <= 1'b0;
          end else if (timeout_hit) begin
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b1;
            tmo_pulse_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mult_dataa   = a_q;
  assign mult_datab   = b_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_product  = rsp_product_q;
  assign rsp_err      = rsp_err_q;
  // The multiplier stays in reset for as long as this block is in reset.
  assign mult_reset_a = ~aclr_n | tmo_pulse_q;

endmodule
